// File: rtl/turbo_block_sched.sv
// Turbo encoder block scheduler: clear, encode, per-encoder termination, interleaver index.
// Optional length screening is enabled by defining TBS_LEN_CHECK_EN.
module turbo_block_sched #(
    parameter int LEN_W       = 13,
    parameter int TAIL_CYCLES = 3,
    parameter int MIN_LEN     = 40,
    parameter int MAX_LEN     = 6144
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_length,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [LEN_W-1:0] bit_idx,
    output logic             enc_clr,
    output logic             enc1_en,
    output logic             enc2_en,
    output logic             tail1_sel,
    output logic             tail2_sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TC_W = ($clog2(TAIL_CYCLES) < 2) ? 2 : $clog2(TAIL_CYCLES);

    typedef enum logic [2:0] {IDLE, CLEAR, ENCODE, TAIL1, TAIL2, DONE} state_t;

    state_t            state, next;
    logic [LEN_W-1:0]  len_q;
    logic [TC_W-1:0]   tail_cnt;
    logic              len_ok;
    logic              last_bit;
    logic              tail_last;

    if (MIN_LEN > MAX_LEN || TAIL_CYCLES < 1) begin : g_cfg_check
        $error("turbo_block_sched: inconsistent length or tail configuration");
    end

`ifdef TBS_LEN_CHECK_EN
    assign len_ok = (req_length >= LEN_W'(MIN_LEN)) && (req_length <= LEN_W'(MAX_LEN));
`else
    assign len_ok = 1'b1;
`endif

    // len_q is nonzero whenever ENCODE is entered, so len_q-1 cannot wrap here
    assign last_bit  = (bit_idx == len_q - LEN_W'(1));
    assign tail_last = (tail_cnt == TC_W'(TAIL_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (req_valid && len_ok) next = CLEAR;
            CLEAR:   next = (len_q != '0) ? ENCODE : TAIL1;
            ENCODE:  if (src_valid && last_bit) next = TAIL1;
            TAIL1:   if (tail_last) next = TAIL2;
            TAIL2:   if (tail_last) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !reset;
        src_ready = (state == ENCODE);
        enc1_en   = ((state == ENCODE) && src_valid) || (state == TAIL1);
        enc2_en   = ((state == ENCODE) && src_valid) || (state == TAIL2);
    end

    // Registered outputs are loaded from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            bit_idx   <= '0;
            tail_cnt  <= '0;
            enc_clr   <= 1'b0;
            tail1_sel <= 1'b0;
            tail2_sel <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            enc_clr   <= (next == CLEAR);
            tail1_sel <= (next == TAIL1);
            tail2_sel <= (next == TAIL2);
            busy      <= (next != IDLE);
            done      <= (next == DONE);
            if ((next == state) && ((state == TAIL1) || (state == TAIL2)))
                tail_cnt <= tail_cnt + TC_W'(1);
            else
                tail_cnt <= '0;
            if ((state == IDLE) && req_valid && len_ok)
                len_q <= req_length;
            if (state == CLEAR)
                bit_idx <= '0;
            else if ((state == ENCODE) && src_valid)
                bit_idx <= last_bit ? '0 : bit_idx + LEN_W'(1);
        end
    end

`ifdef TBS_LEN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else       err <= (state == IDLE) && req_valid && !len_ok;
    end
`else
    assign err = 1'b0;
`endif

endmodule
